frigate_xtal_startup_ctrl: RTL and testbench
============================================

FRIGATE_XTAL_STARTUP_CTRL -- requirements
Module: frigate_xtal_startup_ctrl

Interface
REQ-001 SHALL have parameter STARTUP_CYCLES, default 8000000; crystal settle time in clk cycles (0.5 s at 16 MHz).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 16000; frequency-measurement window in clk cycles (1 ms).
REQ-003 SHALL have parameters MIN_EDGES, default 30, and MAX_EDGES, default 36; the inclusive accepted rising-edge count per window.
REQ-004 SHALL have parameter MAX_RETRIES, default 3; number of startup re-attempts before failure.
REQ-005 SHALL have parameter EDGE_W, default 8; width of the edge counter.
REQ-006 clk  input  1  system clock from the 16 MHz R-C oscillator.
REQ-007 reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-008 req_on  input  1  software request to run the 32 kHz crystal (LSXO).
REQ-009 xo_dout  input  1  LSXO digital output; asynchronous to clk.
REQ-010 xo_ena  output  1  LSXO enable.
REQ-011 xo_standby  output  1  LSXO standby; keeps the output buffer gated during settle.
REQ-012 xo_ready  output  1  crystal verified; downstream may switch its clock to LSXO.
REQ-013 xo_fail  output  1  crystal failed to start, or stopped while running.
REQ-014 edge_count  output  EDGE_W  rising-edge count from the last completed window.

Function
REQ-015 SHALL pass xo_dout through a 2-flop synchronizer plus a history flop; an edge is detected when the second synchronizer flop is 1 and the history flop is 0.
REQ-016 SHALL implement the states OFF, SETTLE, MEASURE, LOCKED and FAIL.
REQ-017 OFF: all outputs 0 and counters cleared; req_on=1 moves to SETTLE on the next cycle.
REQ-018 SETTLE: xo_ena=1 and xo_standby=1; after exactly STARTUP_CYCLES cycles in SETTLE, moves to MEASURE.
REQ-019 MEASURE: xo_ena=1 and xo_standby=0; runs one window of WINDOW_CYCLES cycles, counting edges detected in those cycles, including the final cycle.
REQ-020 At the end of a window, edge_count SHALL load the count and the edge counter SHALL restart at 0.
REQ-021 A MEASURE window with MIN_EDGES <= count <= MAX_EDGES SHALL move to LOCKED; xo_ready=1 from the first LOCKED cycle.
REQ-022 A MEASURE window out of range SHALL move to SETTLE and increment retry_cnt while retry_cnt < MAX_RETRIES; otherwise it SHALL move to FAIL.
REQ-023 LOCKED: windows run back to back. A window with count < MIN_EDGES (including 0, a stopped crystal) SHALL move to FAIL. A window with count > MAX_EDGES SHALL leave the state LOCKED with xo_fail=0 and only update edge_count.
REQ-024 FAIL: xo_ena=0, xo_ready=0 and xo_fail=1; the block stays in FAIL until req_on=0.
REQ-025 req_on=0 in any state SHALL force OFF on the next cycle; xo_ready and xo_fail then clear the same cycle OFF is entered.
REQ-026 The edge counter SHALL saturate at 2^EDGE_W-1.
REQ-027 The settle counter SHALL be ceil(log2(STARTUP_CYCLES+1)) bits wide.
REQ-028 The window counter SHALL be ceil(log2(WINDOW_CYCLES+1)) bits wide.
REQ-029 Edges seen in SETTLE SHALL be ignored, and the edge counter SHALL be held at 0 there.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On reset the block SHALL enter OFF, with every output 0, retry_cnt 0, all counters 0 and the synchronizer flops 0.
REQ-032 Reset asserted mid-operation SHALL take priority over every transition, and xo_ena SHALL drop on the cycle after reset is sampled.

Structure
REQ-033 The state enum and the default parameter constants SHALL live in the shared package frigate_timing_pkg.
REQ-034 The synchronizer and edge detector SHALL be the single sub-module frigate_sync_edge, reused by the future HSXO monitor.

Verification (all scenarios use STARTUP_CYCLES=100, WINDOW_CYCLES=160, MIN_EDGES=3, MAX_EDGES=5, MAX_RETRIES=2)
REQ-035 Nominal: req_on=1 with xo_dout period 40 clk -> xo_ena=1; xo_standby falls after 100 cycles; edge_count=4; xo_ready=1 after the first window.
REQ-036 Dead crystal: xo_dout held at 0 -> 3 SETTLE/MEASURE attempts, then xo_fail=1, xo_ena=0 and edge_count=0.
REQ-037 Stop while locked: after lock, xo_dout freezes -> next window count is 0, xo_ready=0 and xo_fail=1.
REQ-038 Overspeed: xo_dout period 10 clk -> count 16 > 5 -> retries, then FAIL. The same period applied while LOCKED leaves xo_ready=1.
REQ-039 Abort: req_on drops in the middle of SETTLE, and separately in FAIL -> OFF next cycle with all outputs 0; req_on reasserted restarts SETTLE with retry_cnt=0.
REQ-040 Reset at window cycle 80 while in MEASURE -> all outputs 0 the next cycle; edge_count=0.

Source files
------------

// File: rtl/frigate_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frigate_timing_pkg
// Description : Shared state encoding and default timing constants for the
//               Frigate crystal start-up and monitor blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package frigate_timing_pkg;

    // Crystal controller state encoding
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAIL    = 3'd4
    } xo_state_e;

    // Defaults sized for a 32.768 kHz crystal observed from a 16 MHz clock
    localparam int c_DEF_STARTUP_CYCLES = 8000000;  // 0.5 s settle
    localparam int c_DEF_WINDOW_CYCLES  = 16000;    // 1 ms window
    localparam int c_DEF_MIN_EDGES      = 30;
    localparam int c_DEF_MAX_EDGES      = 36;
    localparam int c_DEF_MAX_RETRIES    = 3;
    localparam int c_DEF_EDGE_W         = 8;

endpackage : frigate_timing_pkg
`default_nettype wire

// File: rtl/frigate_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : frigate_sync_edge
// Description : Two-flop synchronizer plus history flop; flags a rising edge
//               of an asynchronous oscillator output in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module frigate_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Metastability filter followed by a one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Rising edge: synchronized level is high, previous sample was low
    assign o_rise = r_sync2 & ~r_hist;

endmodule : frigate_sync_edge
`default_nettype wire

// File: rtl/frigate_xtal_startup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frigate_xtal_startup_ctrl
// Description : Low-speed crystal (LSXO) start-up sequencer. Enables the
//               crystal, waits for it to settle, verifies its frequency by
//               counting edges in fixed windows, and keeps monitoring it once
//               locked. Reports ready / fail to downstream clock switching.
// Revision    : 1.0 - initial release
// ============================================================================
module frigate_xtal_startup_ctrl
    import frigate_timing_pkg::*;
#(
    parameter int STARTUP_CYCLES = c_DEF_STARTUP_CYCLES,
    parameter int WINDOW_CYCLES  = c_DEF_WINDOW_CYCLES,
    parameter int MIN_EDGES      = c_DEF_MIN_EDGES,
    parameter int MAX_EDGES      = c_DEF_MAX_EDGES,
    parameter int MAX_RETRIES    = c_DEF_MAX_RETRIES,
    parameter int EDGE_W         = c_DEF_EDGE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_on,
    input  logic              xo_dout,
    output logic              xo_ena,
    output logic              xo_standby,
    output logic              xo_ready,
    output logic              xo_fail,
    output logic [EDGE_W-1:0] edge_count
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_SETTLE_W = $clog2(STARTUP_CYCLES + 1);
    localparam int c_WIN_W    = $clog2(WINDOW_CYCLES + 1);
    localparam int c_RETRY_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(STARTUP_CYCLES - 1);
    localparam logic [c_WIN_W-1:0]    c_WIN_LAST    = c_WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0]  c_RETRY_MAX   = c_RETRY_W'(MAX_RETRIES);
    localparam logic [EDGE_W-1:0]     c_EDGE_MIN    = EDGE_W'(MIN_EDGES);
    localparam logic [EDGE_W-1:0]     c_EDGE_MAX    = EDGE_W'(MAX_EDGES);
    localparam logic [EDGE_W-1:0]     c_EDGE_SAT    = '1;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    xo_state_e               r_state;
    logic [c_SETTLE_W-1:0]   r_settle_cnt;
    logic [c_WIN_W-1:0]      r_win_cnt;
    logic [EDGE_W-1:0]       r_edge_cnt;
    logic [c_RETRY_W-1:0]    r_retry_cnt;
    logic                    r_xo_ena;
    logic                    r_xo_standby;
    logic                    r_xo_ready;
    logic                    r_xo_fail;
    logic [EDGE_W-1:0]       r_edge_count;

    logic                    w_rise;
    logic [EDGE_W-1:0]       w_edge_next;
    logic                    w_win_last;
    logic                    w_in_range;
    logic                    w_too_few;

    // ------------------------------------------------------------------------
    // Crystal output synchronizer and edge detector
    // ------------------------------------------------------------------------
    frigate_sync_edge u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_din  (xo_dout),
        .o_rise (w_rise)
    );

    // Window bookkeeping: edge count including this cycle, saturating
    always_comb begin
        w_edge_next = r_edge_cnt;
        if (w_rise && (r_edge_cnt != c_EDGE_SAT)) begin
            w_edge_next = r_edge_cnt + EDGE_W'(1);
        end
        w_win_last = (r_win_cnt == c_WIN_LAST);
        w_in_range = (w_edge_next >= c_EDGE_MIN) && (w_edge_next <= c_EDGE_MAX);
        w_too_few  = (w_edge_next < c_EDGE_MIN);
    end

    // Start-up / monitor sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset || !req_on) begin
            // Reset and a dropped request both return to a fully idle block
            r_state      <= ST_OFF;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_retry_cnt  <= '0;
            r_xo_ena     <= 1'b0;
            r_xo_standby <= 1'b0;
            r_xo_ready   <= 1'b0;
            r_xo_fail    <= 1'b0;
            r_edge_count <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= '0;
                    r_win_cnt    <= '0;
                    r_edge_cnt   <= '0;
                    r_retry_cnt  <= '0;
                    r_xo_ena     <= 1'b1;
                    r_xo_standby <= 1'b1;
                end

                ST_SETTLE: begin
                    // Output buffer is gated, so any edges here are noise
                    r_edge_cnt <= '0;
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state      <= ST_MEASURE;
                        r_settle_cnt <= '0;
                        r_win_cnt    <= '0;
                        r_xo_standby <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SETTLE_W'(1);
                    end
                end

                ST_MEASURE: begin
                    if (w_win_last) begin
                        r_edge_count <= w_edge_next;
                        r_edge_cnt   <= '0;
                        r_win_cnt    <= '0;
                        if (w_in_range) begin
                            r_state    <= ST_LOCKED;
                            r_xo_ready <= 1'b1;
                        end else if (r_retry_cnt < c_RETRY_MAX) begin
                            r_state      <= ST_SETTLE;
                            r_retry_cnt  <= r_retry_cnt + c_RETRY_W'(1);
                            r_settle_cnt <= '0;
                            r_xo_standby <= 1'b1;
                        end else begin
                            r_state      <= ST_FAIL;
                            r_xo_ena     <= 1'b0;
                            r_xo_standby <= 1'b0;
                            r_xo_fail    <= 1'b1;
                        end
                    end else begin
                        r_edge_cnt <= w_edge_next;
                        r_win_cnt  <= r_win_cnt + c_WIN_W'(1);
                    end
                end

                ST_LOCKED: begin
                    // Back-to-back windows; only a slow or stopped crystal is fatal
                    if (w_win_last) begin
                        r_edge_count <= w_edge_next;
                        r_edge_cnt   <= '0;
                        r_win_cnt    <= '0;
                        if (w_too_few) begin
                            r_state      <= ST_FAIL;
                            r_xo_ena     <= 1'b0;
                            r_xo_standby <= 1'b0;
                            r_xo_ready   <= 1'b0;
                            r_xo_fail    <= 1'b1;
                        end
                    end else begin
                        r_edge_cnt <= w_edge_next;
                        r_win_cnt  <= r_win_cnt + c_WIN_W'(1);
                    end
                end

                ST_FAIL: begin
                    // Sticky until software withdraws the request
                    r_edge_cnt   <= '0;
                    r_xo_ena     <= 1'b0;
                    r_xo_standby <= 1'b0;
                    r_xo_ready   <= 1'b0;
                    r_xo_fail    <= 1'b1;
                end

                default: begin
                    r_state      <= ST_OFF;
                    r_xo_ena     <= 1'b0;
                    r_xo_standby <= 1'b0;
                    r_xo_ready   <= 1'b0;
                    r_xo_fail    <= 1'b0;
                end
            endcase
        end
    end

    assign xo_ena     = r_xo_ena;
    assign xo_standby = r_xo_standby;
    assign xo_ready   = r_xo_ready;
    assign xo_fail    = r_xo_fail;
    assign edge_count = r_edge_count;

endmodule : frigate_xtal_startup_ctrl
`default_nettype wire

// File: tb/tb_frigate_xtal_startup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frigate_xtal_startup_ctrl
// Description : Directed self-checking bench for the LSXO start-up sequencer:
//               nominal lock, dead crystal, stop while locked, overspeed,
//               aborts and mid-window reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frigate_xtal_startup_ctrl;

    localparam int c_STARTUP = 100;
    localparam int c_WINDOW  = 160;
    localparam int c_MIN     = 3;
    localparam int c_MAX     = 5;
    localparam int c_RETRIES = 2;
    localparam int c_EW      = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_on;
    logic            xo_dout;
    logic            xo_ena;
    logic            xo_standby;
    logic            xo_ready;
    logic            xo_fail;
    logic [c_EW-1:0] edge_count;

    // Crystal model controls (written by the sequence, consumed by the model)
    int   gen_period = 0;
    logic gen_zero   = 1'b1;
    int   gen_cmd    = 0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string     tag;
        logic      ena;
        logic      stby;
        logic      rdy;
        logic      fail;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    frigate_xtal_startup_ctrl #(
        .STARTUP_CYCLES (c_STARTUP),
        .WINDOW_CYCLES  (c_WINDOW),
        .MIN_EDGES      (c_MIN),
        .MAX_EDGES      (c_MAX),
        .MAX_RETRIES    (c_RETRIES),
        .EDGE_W         (c_EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_on     (req_on),
        .xo_dout    (xo_dout),
        .xo_ena     (xo_ena),
        .xo_standby (xo_standby),
        .xo_ready   (xo_ready),
        .xo_fail    (xo_fail),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    // Crystal model: square wave of gen_period clk cycles, updated 2 time
    // units after each rising clk edge; gen_period 0 freezes the level.
    initial begin
        int ph;
        int seen;
        ph      = 0;
        seen    = 0;
        xo_dout = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_cmd != seen) begin
                seen = gen_cmd;
                ph   = 0;
                if (gen_zero) xo_dout = 1'b0;
            end
            if (gen_period != 0) begin
                ph = ph + 1;
                if (ph >= gen_period / 2) begin
                    ph      = 0;
                    xo_dout = ~xo_dout;
                end
            end
        end
    end

    task automatic crystal(input int period, input logic zero);
        gen_period = period;
        gen_zero   = zero;
        gen_cmd    = gen_cmd + 1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push the expected output snapshot, advance n cycles, pop and compare
    task automatic expect_after(input string tag, input int n,
                                input logic e, input logic s, input logic r,
                                input logic f, input logic [7:0] c);
        exp_t x;
        x.tag = tag; x.ena = e; x.stby = s; x.rdy = r; x.fail = f; x.cnt = c;
        sb_q.push_back(x);
        repeat (n) @(negedge clk);
        x = sb_q.pop_front();
        chk({x.tag, ".ena"},  {7'd0, xo_ena},     {7'd0, x.ena});
        chk({x.tag, ".stby"}, {7'd0, xo_standby}, {7'd0, x.stby});
        chk({x.tag, ".rdy"},  {7'd0, xo_ready},   {7'd0, x.rdy});
        chk({x.tag, ".fail"}, {7'd0, xo_fail},    {7'd0, x.fail});
        chk({x.tag, ".cnt"},  edge_count,         x.cnt);
    endtask

    initial begin
        reset  = 1'b1;
        req_on = 1'b0;

        // Reset state
        expect_after("reset", 3, 0, 0, 0, 0, 8'd0);
        reset = 1'b0;
        expect_after("idle", 1, 0, 0, 0, 0, 8'd0);

        // Nominal lock, period 40 -> 4 edges per window
        crystal(40, 1'b1);
        req_on = 1'b1;
        expect_after("nom_settle0", 1,   1, 1, 0, 0, 8'd0);
        expect_after("nom_settle99", 99, 1, 1, 0, 0, 8'd0);
        expect_after("nom_measure", 1,   1, 0, 0, 0, 8'd0);
        expect_after("nom_win_pre", 159, 1, 0, 0, 0, 8'd0);
        expect_after("nom_lock", 1,      1, 0, 1, 0, 8'd4);

        // Overspeed while locked: period 10 keeps lock, count reported high
        crystal(10, 1'b0);
        expect_after("ovl_pre", 159, 1, 0, 1, 0, 8'd4);
        expect_after("ovl_win", 1,   1, 0, 1, 0, 8'd16);

        // Abort from LOCKED
        req_on = 1'b0;
        expect_after("abort_lock", 1, 0, 0, 0, 0, 8'd0);

        // Stop while locked
        crystal(40, 1'b1);
        req_on = 1'b1;
        expect_after("stop_settle", 1,  1, 1, 0, 0, 8'd0);
        expect_after("stop_meas", 249,  1, 0, 0, 0, 8'd0);
        crystal(0, 1'b1);
        expect_after("stop_lock", 11,   1, 0, 1, 0, 8'd4);
        expect_after("stop_pre", 159,   1, 0, 1, 0, 8'd4);
        expect_after("stop_fail", 1,    0, 0, 0, 1, 8'd0);
        expect_after("stop_hold", 5,    0, 0, 0, 1, 8'd0);

        // Abort from FAIL
        req_on = 1'b0;
        expect_after("abort_fail", 1, 0, 0, 0, 0, 8'd0);

        // Dead crystal: three attempts then FAIL
        req_on = 1'b1;
        expect_after("dead_retry1", 261, 1, 1, 0, 0, 8'd0);
        expect_after("dead_last", 519,   1, 0, 0, 0, 8'd0);
        expect_after("dead_fail", 1,     0, 0, 0, 1, 8'd0);
        req_on = 1'b0;
        expect_after("dead_off", 1,      0, 0, 0, 0, 8'd0);

        // Re-request after FAIL: retry budget must be fresh
        req_on = 1'b1;
        expect_after("dead2_last", 780, 1, 0, 0, 0, 8'd0);
        expect_after("dead2_fail", 1,   0, 0, 0, 1, 8'd0);
        req_on = 1'b0;
        expect_after("dead2_off", 1,    0, 0, 0, 0, 8'd0);

        // Overspeed at start-up: 16 edges, retries, then FAIL
        crystal(10, 1'b1);
        req_on = 1'b1;
        expect_after("ovs_retry1", 261, 1, 1, 0, 0, 8'd16);
        expect_after("ovs_fail", 520,   0, 0, 0, 1, 8'd16);
        req_on = 1'b0;
        expect_after("ovs_off", 1,      0, 0, 0, 0, 8'd0);

        // Abort in the middle of SETTLE, then restart
        crystal(40, 1'b1);
        req_on = 1'b1;
        expect_after("ab_settle", 50,  1, 1, 0, 0, 8'd0);
        req_on = 1'b0;
        expect_after("ab_off", 1,      0, 0, 0, 0, 8'd0);
        req_on = 1'b1;
        expect_after("ab_restart", 1,  1, 1, 0, 0, 8'd0);
        expect_after("ab_measure", 100, 1, 0, 0, 0, 8'd0);
        req_on = 1'b0;
        expect_after("ab_off2", 1,     0, 0, 0, 0, 8'd0);

        // Reset at window cycle 80 of MEASURE
        crystal(40, 1'b1);
        req_on = 1'b1;
        expect_after("rst_meas", 180, 1, 0, 0, 0, 8'd0);
        reset = 1'b1;
        expect_after("rst_hit", 1,    0, 0, 0, 0, 8'd0);
        expect_after("rst_hold", 1,   0, 0, 0, 0, 8'd0);
        reset = 1'b0;
        expect_after("rst_rel", 1,    1, 1, 0, 0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_frigate_xtal_startup_ctrl
`default_nettype wire
